gjc7_fifo_ctrl: RTL and testbench

GJC7_FIFO_CTRL -- requirements
Module: gjc7_fifo_ctrl

---
 rtl/gjc7_fifo_ctrl.sv | 173 +++++++++++++++++
 tb/tb_gjc7_fifo_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gjc7_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// gjc7_fifo_ctrl
//
// Controller for a single-clock FIFO built around an external simple
// dual-port RAM with a 1-cycle registered read port. The RAM's CLKA and CLKB
// must both be driven from the same net as CLK.
//
// The RAM read register acts as a one-entry output stage. out_vld marks that
// this stage holds a word the consumer has not yet taken, so M_DATA is wired
// straight to RAM_DOUT. The RAM holds its read data while RE=0, so the output
// stays stable during a stall.
//
// Occupancy is split between ram_cnt (written, not yet read-issued) and
// out_vld. COUNT is their registered sum, so the FIFO holds DEPTH+1 words.
//
// Ports
//   CLK          single clock
//   RST          synchronous active-high reset
//   S_VALID      write-side valid
//   S_READY      write-side ready (low while the RAM is full or in reset)
//   S_DATA       write-side data
//   M_VALID      read-side valid
//   M_READY      read-side ready
//   M_DATA       read-side data (= RAM_DOUT)
//   RAM_WE       RAM write enable
//   RAM_ADDRA    RAM write address
//   RAM_DIN      RAM write data
//   RAM_RE       RAM read enable
//   RAM_ADDRB    RAM read address
//   RAM_DOUT     RAM registered read data
//   COUNT        total occupancy, 0..DEPTH+1
//   FULL         RAM-resident entries equal DEPTH
//   EMPTY        COUNT == 0
//   ALMOST_FULL  COUNT >= AF_LEVEL
// ----------------------------------------------------------------------------
module gjc7_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 36,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned AF_LEVEL   = 480
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [DATA_WIDTH-1:0] S_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  RAM_WE,
    output logic [ADDR_WIDTH-1:0] RAM_ADDRA,
    output logic [DATA_WIDTH-1:0] RAM_DIN,
    output logic                  RAM_RE,
    output logic [ADDR_WIDTH-1:0] RAM_ADDRB,
    input  logic [DATA_WIDTH-1:0] RAM_DOUT,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL
);

    // DEPTH = 2**ADDR_WIDTH, expressed at counter width.
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] MAX_CNT   = DEPTH_CNT + (ADDR_WIDTH + 1)'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] wptr, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr, rptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt, ram_cnt_d;
    logic                  out_vld, out_vld_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    logic full;
    logic push;
    logic rd_issue;
    logic pop;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    always_comb begin
        // FULL looks only at registered state, so a read issued this cycle
        // cannot open a write slot until the next cycle.
        full     = (ram_cnt == DEPTH_CNT);
        S_READY  = !full && !RST;
        push     = S_VALID && S_READY;
        // ram_cnt only counts writes completed at a prior edge, so a read
        // never targets the entry being written in the same cycle.
        rd_issue = !RST && (ram_cnt != '0) && (!out_vld || M_READY);
        pop      = out_vld && M_READY;
    end

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        wptr_d    = wptr;
        rptr_d    = rptr;
        ram_cnt_d = ram_cnt;
        out_vld_d = out_vld;

        if (push) begin
            wptr_d = wptr + ADDR_WIDTH'(1);
        end
        if (rd_issue) begin
            rptr_d = rptr + ADDR_WIDTH'(1);
        end

        unique case ({push, rd_issue})
            2'b10:   ram_cnt_d = ram_cnt + (ADDR_WIDTH + 1)'(1);
            2'b01:   ram_cnt_d = ram_cnt - (ADDR_WIDTH + 1)'(1);
            default: ram_cnt_d = ram_cnt;
        endcase

        // A new read refills the output stage in the same edge that the
        // consumer drains it, so back-to-back reads keep out_vld high.
        if (rd_issue) begin
            out_vld_d = 1'b1;
        end else if (pop) begin
            out_vld_d = 1'b0;
        end

        count_d = ram_cnt_d + {{ADDR_WIDTH{1'b0}}, out_vld_d};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            out_vld <= 1'b0;
            count_q <= '0;
        end else begin
            wptr    <= wptr_d;
            rptr    <= rptr_d;
            ram_cnt <= ram_cnt_d;
            out_vld <= out_vld_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        RAM_WE      = push;
        RAM_ADDRA   = wptr;
        RAM_DIN     = S_DATA;
        RAM_RE      = rd_issue;
        RAM_ADDRB   = rptr;
        M_VALID     = out_vld;
        M_DATA      = RAM_DOUT;
        COUNT       = count_q;
        FULL        = full;
        EMPTY       = (count_q == '0);
        ALMOST_FULL = (count_q >= AF_CNT);
    end

`ifndef SYNTHESIS
    // Same-entry read and write in one cycle would return stale data.
    a_no_rw_same_addr : assert property (@(posedge CLK) disable iff (RST)
        !(RAM_WE && RAM_RE && (RAM_ADDRA == RAM_ADDRB)));

    a_count_range : assert property (@(posedge CLK) disable iff (RST)
        count_q <= MAX_CNT);

    a_no_read_in_stall : assert property (@(posedge CLK) disable iff (RST)
        (out_vld && !M_READY) |-> !RAM_RE);
`endif

endmodule

// File: tb/tb_gjc7_fifo_ctrl.sv
module tb_gjc7_fifo_ctrl;

    localparam int DW = 36;
    localparam int AW = 9;

    logic          CLK = 1'b0;
    logic          RST;
    logic          S_VALID;
    logic          S_READY;
    logic [DW-1:0] S_DATA;
    logic          M_VALID;
    logic          M_READY;
    logic [DW-1:0] M_DATA;
    logic          RAM_WE;
    logic [AW-1:0] RAM_ADDRA;
    logic [DW-1:0] RAM_DIN;
    logic          RAM_RE;
    logic [AW-1:0] RAM_ADDRB;
    logic [DW-1:0] RAM_DOUT;
    logic [AW:0]   COUNT;
    logic          FULL;
    logic          EMPTY;
    logic          ALMOST_FULL;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    gjc7_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_LEVEL  (480)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .S_VALID    (S_VALID),
        .S_READY    (S_READY),
        .S_DATA     (S_DATA),
        .M_VALID    (M_VALID),
        .M_READY    (M_READY),
        .M_DATA     (M_DATA),
        .RAM_WE     (RAM_WE),
        .RAM_ADDRA  (RAM_ADDRA),
        .RAM_DIN    (RAM_DIN),
        .RAM_RE     (RAM_RE),
        .RAM_ADDRB  (RAM_ADDRB),
        .RAM_DOUT   (RAM_DOUT),
        .COUNT      (COUNT),
        .FULL       (FULL),
        .EMPTY      (EMPTY),
        .ALMOST_FULL(ALMOST_FULL)
    );

    // RAM model: write-first not needed, read register holds while RE=0.
    logic [DW-1:0] mem [512];
    always @(posedge CLK) begin
        if (RAM_WE) mem[RAM_ADDRA] <= RAM_DIN;
        if (RAM_RE) RAM_DOUT <= mem[RAM_ADDRB];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Advance one clock; stimulus and checks happen at the falling edge.
    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset;
        RST = 1'b1; S_VALID = 1'b1; M_READY = 1'b1; S_DATA = 36'h1;
        @(negedge CLK);
        #1;
        n_checks++; if (S_READY !== 1'b0) $display("FAIL rst_s_ready got %b want 0", S_READY); else n_pass++;
        n_checks++; if (RAM_WE !== 1'b0) $display("FAIL rst_ram_we got %b want 0", RAM_WE); else n_pass++;
        n_checks++; if (RAM_RE !== 1'b0) $display("FAIL rst_ram_re got %b want 0", RAM_RE); else n_pass++;
        tick();
        RST = 1'b0; S_VALID = 1'b0; M_READY = 1'b0;
        #1;
        n_checks++; if (COUNT !== 10'd0) $display("FAIL rst_count got %0d want 0", COUNT); else n_pass++;
        n_checks++; if (EMPTY !== 1'b1) $display("FAIL rst_empty got %b want 1", EMPTY); else n_pass++;
        n_checks++; if (FULL !== 1'b0) $display("FAIL rst_full got %b want 0", FULL); else n_pass++;
        n_checks++; if (ALMOST_FULL !== 1'b0) $display("FAIL rst_af got %b want 0", ALMOST_FULL); else n_pass++;
        n_checks++; if (M_VALID !== 1'b0) $display("FAIL rst_m_valid got %b want 0", M_VALID); else n_pass++;
        n_checks++; if (S_READY !== 1'b1) $display("FAIL rst_release_s_ready got %b want 1", S_READY); else n_pass++;
    endtask

    task automatic test_single;
        S_VALID = 1'b1; S_DATA = 36'h123456789; M_READY = 1'b0;
        #1;
        n_checks++; if (RAM_WE !== 1'b1) $display("FAIL single_we got %b want 1", RAM_WE); else n_pass++;
        n_checks++; if (RAM_ADDRA !== 9'd0) $display("FAIL single_addra got %0d want 0", RAM_ADDRA); else n_pass++;
        n_checks++; if (RAM_DIN !== 36'h123456789) $display("FAIL single_din got %h want 123456789", RAM_DIN); else n_pass++;
        tick();
        S_VALID = 1'b0;
        #1;
        n_checks++; if (M_VALID !== 1'b0) $display("FAIL single_t1_valid got %b want 0", M_VALID); else n_pass++;
        n_checks++; if (RAM_RE !== 1'b1) $display("FAIL single_t1_re got %b want 1", RAM_RE); else n_pass++;
        n_checks++; if (RAM_ADDRB !== 9'd0) $display("FAIL single_t1_addrb got %0d want 0", RAM_ADDRB); else n_pass++;
        n_checks++; if (COUNT !== 10'd1) $display("FAIL single_t1_count got %0d want 1", COUNT); else n_pass++;
        tick();
        #1;
        n_checks++; if (M_VALID !== 1'b1) $display("FAIL single_t2_valid got %b want 1", M_VALID); else n_pass++;
        n_checks++; if (M_DATA !== 36'h123456789) $display("FAIL single_t2_data got %h want 123456789", M_DATA); else n_pass++;
        n_checks++; if (COUNT !== 10'd1) $display("FAIL single_t2_count got %0d want 1", COUNT); else n_pass++;
        n_checks++; if (RAM_RE !== 1'b0) $display("FAIL single_t2_re got %b want 0", RAM_RE); else n_pass++;
        tick();
        n_checks++; if (COUNT !== 10'd1) $display("FAIL single_hold_count got %0d want 1", COUNT); else n_pass++;
        M_READY = 1'b1;
        tick();
        M_READY = 1'b0;
        n_checks++; if (M_VALID !== 1'b0) $display("FAIL single_pop_valid got %b want 0", M_VALID); else n_pass++;
        n_checks++; if (COUNT !== 10'd0) $display("FAIL single_pop_count got %0d want 0", COUNT); else n_pass++;
        n_checks++; if (EMPTY !== 1'b1) $display("FAIL single_pop_empty got %b want 1", EMPTY); else n_pass++;
    endtask

    task automatic test_fill;
        int refused = 0;
        int exp = 0;
        int bad = 0;
        M_READY = 1'b0;
        for (int k = 1; k <= 513; k++) begin
            S_VALID = 1'b1; S_DATA = DW'(k - 1);
            #1;
            if (S_READY !== 1'b1) refused++;
            tick();
            if (k == 479) begin
                n_checks++; if (ALMOST_FULL !== 1'b0) $display("FAIL fill_af_479 got %b want 0", ALMOST_FULL); else n_pass++;
            end
            if (k == 480) begin
                n_checks++; if (COUNT !== 10'd480) $display("FAIL fill_count_480 got %0d want 480", COUNT); else n_pass++;
                n_checks++; if (ALMOST_FULL !== 1'b1) $display("FAIL fill_af_480 got %b want 1", ALMOST_FULL); else n_pass++;
            end
            if (k == 512) begin
                n_checks++; if (FULL !== 1'b0) $display("FAIL fill_full_512 got %b want 0", FULL); else n_pass++;
            end
        end
        n_checks++; if (refused !== 0) $display("FAIL fill_refused got %0d want 0", refused); else n_pass++;
        n_checks++; if (COUNT !== 10'd513) $display("FAIL fill_count got %0d want 513", COUNT); else n_pass++;
        n_checks++; if (FULL !== 1'b1) $display("FAIL fill_full got %b want 1", FULL); else n_pass++;
        n_checks++; if (S_READY !== 1'b0) $display("FAIL fill_s_ready got %b want 0", S_READY); else n_pass++;
        // Write attempt while full must be ignored.
        S_VALID = 1'b1; S_DATA = 36'hBAD;
        #1;
        n_checks++; if (RAM_WE !== 1'b0) $display("FAIL full_ignore_we got %b want 0", RAM_WE); else n_pass++;
        tick();
        n_checks++; if (COUNT !== 10'd513) $display("FAIL full_ignore_count got %0d want 513", COUNT); else n_pass++;
        // Read issue while full does not allow a same-cycle push.
        M_READY = 1'b1;
        #1;
        n_checks++; if (RAM_WE !== 1'b0) $display("FAIL full_pop_we got %b want 0", RAM_WE); else n_pass++;
        n_checks++; if (RAM_RE !== 1'b1) $display("FAIL full_pop_re got %b want 1", RAM_RE); else n_pass++;
        n_checks++; if (M_DATA !== 36'd0) $display("FAIL full_pop_data got %h want 0", M_DATA); else n_pass++;
        exp = 1;
        tick();
        S_VALID = 1'b0;
        n_checks++; if (S_READY !== 1'b1) $display("FAIL full_pop_s_ready got %b want 1", S_READY); else n_pass++;
        n_checks++; if (COUNT !== 10'd512) $display("FAIL full_pop_count got %0d want 512", COUNT); else n_pass++;
        for (int c = 0; c < 600 && exp < 513; c++) begin
            if (M_VALID === 1'b1) begin
                if (M_DATA !== DW'(exp)) bad++;
                exp++;
            end
            tick();
        end
        M_READY = 1'b0;
        n_checks++; if (exp !== 513) $display("FAIL fill_drain_count got %0d want 513", exp); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL fill_drain_order got %0d bad words want 0", bad); else n_pass++;
        n_checks++; if (EMPTY !== 1'b1) $display("FAIL fill_drain_empty got %b want 1", EMPTY); else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [15:0]   lfsr = 16'hACE1;
        logic [DW-1:0] prev_data = '0;
        logic          prev_stall = 1'b0;
        int sent = 0, got = 0, bad_order = 0, bad_stable = 0, bad_re = 0;
        for (int c = 0; c < 2000 && got < 100; c++) begin
            lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            M_READY = lfsr[0];
            S_VALID = (sent < 100);
            S_DATA  = DW'(sent);
            #1;
            if (prev_stall && M_VALID && (M_DATA !== prev_data)) bad_stable++;
            if (M_VALID && !M_READY && RAM_RE) bad_re++;
            if (M_VALID && M_READY) begin
                if (M_DATA !== DW'(got)) bad_order++;
                got++;
            end
            if (S_VALID && S_READY) sent++;
            prev_stall = M_VALID && !M_READY;
            prev_data  = M_DATA;
            tick();
        end
        S_VALID = 1'b0; M_READY = 1'b0;
        n_checks++; if (got !== 100) $display("FAIL bp_count got %0d want 100", got); else n_pass++;
        n_checks++; if (bad_order !== 0) $display("FAIL bp_order got %0d bad want 0", bad_order); else n_pass++;
        n_checks++; if (bad_stable !== 0) $display("FAIL bp_stable got %0d bad want 0", bad_stable); else n_pass++;
        n_checks++; if (bad_re !== 0) $display("FAIL bp_stall_re got %0d bad want 0", bad_re); else n_pass++;
        n_checks++; if (EMPTY !== 1'b1) $display("FAIL bp_empty got %b want 1", EMPTY); else n_pass++;
    endtask

    task automatic test_wrap;
        int sent = 0, got = 0, bad = 0, wraps_w = 0, wraps_r = 0;
        int last_wa = -1, last_ra = -1;
        for (int c = 0; c < 2000 && got < 1500; c++) begin
            M_READY = (sent >= 10);
            S_VALID = (sent < 1500);
            S_DATA  = DW'(32'h40000 + sent);
            #1;
            if (sent == 800 && S_VALID) begin
                n_checks++; if (COUNT !== 10'd10) $display("FAIL wrap_steady_count got %0d want 10", COUNT); else n_pass++;
            end
            if (RAM_WE) begin
                if (RAM_ADDRA == 9'd0 && last_wa == 511) wraps_w++;
                last_wa = int'(RAM_ADDRA);
            end
            if (RAM_RE) begin
                if (RAM_ADDRB == 9'd0 && last_ra == 511) wraps_r++;
                last_ra = int'(RAM_ADDRB);
            end
            if (M_VALID && M_READY) begin
                if (M_DATA !== DW'(32'h40000 + got)) bad++;
                got++;
            end
            if (S_VALID && S_READY) sent++;
            tick();
        end
        S_VALID = 1'b0; M_READY = 1'b0;
        n_checks++; if (got !== 1500) $display("FAIL wrap_count got %0d want 1500", got); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL wrap_order got %0d bad want 0", bad); else n_pass++;
        n_checks++; if (wraps_w < 2) $display("FAIL wrap_wptr got %0d wraps want >=2", wraps_w); else n_pass++;
        n_checks++; if (wraps_r < 2) $display("FAIL wrap_rptr got %0d wraps want >=2", wraps_r); else n_pass++;
    endtask

    task automatic test_simultaneous;
        int got = 0, bad_order = 0, bad_count = 0;
        M_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            S_VALID = 1'b1; S_DATA = DW'(32'h5000 + i);
            tick();
        end
        n_checks++; if (COUNT !== 10'd5) $display("FAIL sim_start_count got %0d want 5", COUNT); else n_pass++;
        for (int i = 0; i < 50; i++) begin
            S_VALID = 1'b1; M_READY = 1'b1; S_DATA = DW'(32'h5000 + 5 + i);
            #1;
            if (M_VALID && M_READY) begin
                if (M_DATA !== DW'(32'h5000 + got)) bad_order++;
                got++;
            end
            tick();
            if (COUNT !== 10'd5) bad_count++;
        end
        n_checks++; if (bad_count !== 0) $display("FAIL sim_count_steady got %0d bad cycles want 0", bad_count); else n_pass++;
        S_VALID = 1'b0;
        for (int c = 0; c < 20 && !EMPTY; c++) begin
            #1;
            if (M_VALID && M_READY) begin
                if (M_DATA !== DW'(32'h5000 + got)) bad_order++;
                got++;
            end
            tick();
        end
        M_READY = 1'b0;
        n_checks++; if (got !== 55) $display("FAIL sim_total got %0d want 55", got); else n_pass++;
        n_checks++; if (bad_order !== 0) $display("FAIL sim_order got %0d bad want 0", bad_order); else n_pass++;
    endtask

    task automatic test_mid_reset;
        M_READY = 1'b0;
        for (int i = 0; i < 200; i++) begin
            S_VALID = 1'b1; S_DATA = DW'(32'h7000 + i);
            tick();
        end
        n_checks++; if (COUNT !== 10'd200) $display("FAIL mrst_pre_count got %0d want 200", COUNT); else n_pass++;
        RST = 1'b1; S_VALID = 1'b1; M_READY = 1'b1;
        #1;
        n_checks++; if (S_READY !== 1'b0) $display("FAIL mrst_s_ready got %b want 0", S_READY); else n_pass++;
        n_checks++; if (RAM_RE !== 1'b0) $display("FAIL mrst_re got %b want 0", RAM_RE); else n_pass++;
        tick();
        RST = 1'b0; S_VALID = 1'b0; M_READY = 1'b0;
        n_checks++; if (COUNT !== 10'd0) $display("FAIL mrst_count got %0d want 0", COUNT); else n_pass++;
        n_checks++; if (EMPTY !== 1'b1) $display("FAIL mrst_empty got %b want 1", EMPTY); else n_pass++;
        n_checks++; if (M_VALID !== 1'b0) $display("FAIL mrst_m_valid got %b want 0", M_VALID); else n_pass++;
        S_VALID = 1'b1; S_DATA = 36'hA5; M_READY = 1'b1;
        #1;
        n_checks++; if (RAM_ADDRA !== 9'd0) $display("FAIL mrst_addra got %0d want 0", RAM_ADDRA); else n_pass++;
        tick();
        S_VALID = 1'b0;
        n_checks++; if (M_VALID !== 1'b0) $display("FAIL mrst_t1_valid got %b want 0", M_VALID); else n_pass++;
        tick();
        n_checks++; if (M_VALID !== 1'b1) $display("FAIL mrst_t2_valid got %b want 1", M_VALID); else n_pass++;
        n_checks++; if (M_DATA !== 36'hA5) $display("FAIL mrst_first_word got %h want a5", M_DATA); else n_pass++;
        tick();
        M_READY = 1'b0;
        n_checks++; if (EMPTY !== 1'b1) $display("FAIL mrst_final_empty got %b want 1", EMPTY); else n_pass++;
    endtask

    initial begin
        RST = 1'b1; S_VALID = 1'b0; M_READY = 1'b0; S_DATA = '0;
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_wrap();
        test_simultaneous();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
